// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared control definitions for the RV32I decode/control pipeline:
// opcodes, ALU-control codes, immediate/result-select codes, branch kinds,
// and the control bundle carried from ID into the pipe registers.
package riscv_ctrl_pkg;

    // Base-ISA major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU control codes
    localparam int ALU_W = 4;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd9;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Write-back result select
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_IMM  = 2'b11;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_LT   = 4'd3,
        BR_GE   = 4'd4,
        BR_LTU  = 4'd5,
        BR_GEU  = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    // Everything decoded from one instruction
    typedef struct packed {
        logic             legal;
        logic             reg_write;
        logic             mem_write;
        logic             alu_src;
        logic             alu_a_pc;
        logic [ALU_W-1:0] alu_ctrl;
        logic [1:0]       result_src;
        br_type_e         br_type;
        logic             jalr;
        logic [2:0]       imm_src;
    } ctrl_t;

    // The subset of controls still needed after EX
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } post_t;

    // R-type / I-type arithmetic: SUB exists only for R-type, SRA for both
    function automatic logic [ALU_W-1:0] arith_alu(input logic [2:0] funct3,
                                                   input logic       f7b5,
                                                   input logic       is_rtype);
        case (funct3)
            3'b000:  arith_alu = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_alu = ALU_SLL;
            3'b010:  arith_alu = ALU_SLT;
            3'b011:  arith_alu = ALU_SLTU;
            3'b100:  arith_alu = ALU_XOR;
            3'b101:  arith_alu = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_alu = ALU_OR;
            default: arith_alu = ALU_AND;
        endcase
    endfunction

    // Branches compare with SUB (equality via zero flag) or SLT/SLTU
    function automatic logic [ALU_W-1:0] branch_alu(input logic [2:0] funct3);
        case (funct3)
            3'b100, 3'b101: branch_alu = ALU_SLT;
            3'b110, 3'b111: branch_alu = ALU_SLTU;
            default:        branch_alu = ALU_SUB;
        endcase
    endfunction

    function automatic br_type_e branch_kind(input logic [2:0] funct3);
        case (funct3)
            3'b000:  branch_kind = BR_EQ;
            3'b001:  branch_kind = BR_NE;
            3'b100:  branch_kind = BR_LT;
            3'b101:  branch_kind = BR_GE;
            3'b110:  branch_kind = BR_LTU;
            3'b111:  branch_kind = BR_GEU;
            default: branch_kind = BR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// ID-side inputs, EX flags and pipeline control outputs of decode_ctrl_pipe.
// master = environment (hazard unit / datapath), slave = the control pipe.
interface decode_ctrl_pipe_if #(
    parameter int ALUCTRL_W = 4
);
    logic                 id_valid;
    logic [31:0]          id_instr;
    logic                 stall;
    logic                 flush_ext;
    logic                 ex_zero;
    logic                 ex_lt;
    logic                 ex_ltu;
    logic [2:0]           id_imm_src;
    logic                 ex_valid;
    logic                 ex_alu_src;
    logic                 ex_alu_a_pc;
    logic [ALUCTRL_W-1:0] ex_alu_ctrl;
    logic                 ex_pcsrc;
    logic                 ex_jalr;
    logic                 mem_valid;
    logic                 mem_mem_write;
    logic                 wb_valid;
    logic                 wb_reg_write;
    logic [1:0]           wb_result_src;
    logic                 trap;

    modport master (
        output id_valid, id_instr, stall, flush_ext, ex_zero, ex_lt, ex_ltu,
        input  id_imm_src, ex_valid, ex_alu_src, ex_alu_a_pc, ex_alu_ctrl,
               ex_pcsrc, ex_jalr, mem_valid, mem_mem_write, wb_valid,
               wb_reg_write, wb_result_src, trap
    );

    modport slave (
        input  id_valid, id_instr, stall, flush_ext, ex_zero, ex_lt, ex_ltu,
        output id_imm_src, ex_valid, ex_alu_src, ex_alu_a_pc, ex_alu_ctrl,
               ex_pcsrc, ex_jalr, mem_valid, mem_mem_write, wb_valid,
               wb_reg_write, wb_result_src, trap
    );
endinterface

// File: rtl/decode_ctrl_pipe_ctrl_decode.sv
// ctrl_decode: purely combinational RV32I instruction -> control bundle.
// Unknown opcodes return an all-zero bundle (legal=0), i.e. a bubble.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];

    // Register numbers and immediate bits are datapath concerns, not control
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Main decoder plus ALU decoder, bubble by default
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LOAD: begin
                ctrl.legal      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_LOAD;
                ctrl.imm_src    = IMM_I;
            end
            OP_STORE: begin
                ctrl.legal     = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.imm_src   = IMM_S;
            end
            OP_OP: begin
                ctrl.legal     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = arith_alu(funct3, f7b5, 1'b1);
            end
            OP_IMM: begin
                ctrl.legal     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = arith_alu(funct3, f7b5, 1'b0);
                ctrl.imm_src   = IMM_I;
            end
            OP_BRANCH: begin
                // funct3 010/011 are not branches: they pass as a harmless NOP
                ctrl.legal    = 1'b1;
                ctrl.alu_ctrl = branch_alu(funct3);
                ctrl.br_type  = branch_kind(funct3);
                ctrl.imm_src  = IMM_B;
            end
            OP_JAL: begin
                ctrl.legal      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_a_pc   = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_PC4;
                ctrl.br_type    = BR_JAL;
                ctrl.imm_src    = IMM_J;
            end
            OP_JALR: begin
                ctrl.legal      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_PC4;
                ctrl.br_type    = BR_JALR;
                ctrl.jalr       = 1'b1;
                ctrl.imm_src    = IMM_I;
            end
            OP_LUI: begin
                ctrl.legal      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_IMM;
                ctrl.imm_src    = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.legal     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_a_pc  = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.imm_src   = IMM_U;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RV32I control pipeline. Decodes the ID instruction,
// carries controls through ID/EX and POST_EX post-EX stages (MEM ... WB),
// resolves branches/jumps in EX and applies stall/flush to ID/EX.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (sticky illegal-opcode trap).
module decode_ctrl_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int POST_EX   = 2     // legal range 1..4
) (
    input logic               clk,
    input logic               rst,
    decode_ctrl_pipe_if.slave bus
);

    ctrl_t dec_ctrl;

    ctrl_decode u_decode (
        .instr (bus.id_instr),
        .ctrl  (dec_ctrl)
    );

    logic  ex_valid_reg, ex_valid_next;
    ctrl_t ex_ctrl_reg,  ex_ctrl_next;
    logic  ex_pcsrc;
    logic  flush;
    logic  trap_block;

    assign flush = ex_pcsrc | bus.flush_ext;

    // ID/EX next value: flush beats stall beats load; anything not loaded is a bubble
    always_comb begin
        ex_valid_next = 1'b0;
        ex_ctrl_next  = '0;
        if (flush) begin
            ex_valid_next = 1'b0;
        end else if (bus.stall) begin
            ex_valid_next = 1'b0;
        end else if (bus.id_valid && dec_ctrl.legal && !trap_block) begin
            ex_valid_next = 1'b1;
            ex_ctrl_next  = dec_ctrl;
        end
    end

    // ID/EX pipe register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg <= 1'b0;
            ex_ctrl_reg  <= '0;
        end else begin
            ex_valid_reg <= ex_valid_next;
            ex_ctrl_reg  <= ex_ctrl_next;
        end
    end

    // Branch resolver: redirect decision from EX flags, only for a live instruction
    always_comb begin
        ex_pcsrc = 1'b0;
        if (ex_valid_reg) begin
            case (ex_ctrl_reg.br_type)
                BR_EQ:   ex_pcsrc = bus.ex_zero;
                BR_NE:   ex_pcsrc = !bus.ex_zero;
                BR_LT:   ex_pcsrc = bus.ex_lt;
                BR_GE:   ex_pcsrc = !bus.ex_lt;
                BR_LTU:  ex_pcsrc = bus.ex_ltu;
                BR_GEU:  ex_pcsrc = !bus.ex_ltu;
                BR_JAL,
                BR_JALR: ex_pcsrc = 1'b1;
                default: ex_pcsrc = 1'b0;
            endcase
        end
    end

    // Post-EX shift chain: never stalled or flushed, advances every cycle
    post_t ex_post;
    post_t stage_in [POST_EX];
    post_t stage_q  [POST_EX];

    assign ex_post = '{valid:      ex_valid_reg,
                       reg_write:  ex_ctrl_reg.reg_write,
                       mem_write:  ex_ctrl_reg.mem_write,
                       result_src: ex_ctrl_reg.result_src};

    for (genvar gi = 0; gi < POST_EX; gi++) begin : g_post
        post_t stage_reg;

        if (gi == 0) begin : g_head
            assign stage_in[gi] = ex_post;
        end else begin : g_link
            assign stage_in[gi] = stage_q[gi-1];
        end

        // One post-EX stage: copy the previous stage each clock
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_reg <= '0;
            end else begin
                stage_reg <= stage_in[gi];
            end
        end

        assign stage_q[gi] = stage_reg;
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic trap_reg, trap_next;

    // Sticky trap: set by a live illegal opcode unless it is being flushed
    always_comb begin
        trap_next = trap_reg | (bus.id_valid & ~dec_ctrl.legal & ~flush);
    end

    // Trap flop, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_reg <= 1'b0;
        end else begin
            trap_reg <= trap_next;
        end
    end

    assign trap_block = trap_reg;
    assign bus.trap   = trap_reg;
`else
    assign trap_block = 1'b0;
    assign bus.trap   = 1'b0;
`endif

    // Legality and immediate format are consumed in ID only
    logic unused_ex_fields;
    assign unused_ex_fields = ^{ex_ctrl_reg.legal, ex_ctrl_reg.imm_src};

    assign bus.id_imm_src    = dec_ctrl.imm_src;
    assign bus.ex_valid      = ex_valid_reg;
    assign bus.ex_alu_src    = ex_ctrl_reg.alu_src;
    assign bus.ex_alu_a_pc   = ex_ctrl_reg.alu_a_pc;
    assign bus.ex_alu_ctrl   = ALUCTRL_W'(ex_ctrl_reg.alu_ctrl);
    assign bus.ex_pcsrc      = ex_pcsrc;
    assign bus.ex_jalr       = ex_valid_reg & ex_ctrl_reg.jalr;
    assign bus.mem_valid     = stage_q[0].valid;
    assign bus.mem_mem_write = stage_q[0].valid & stage_q[0].mem_write;
    assign bus.wb_valid      = stage_q[POST_EX-1].valid;
    assign bus.wb_reg_write  = stage_q[POST_EX-1].valid & stage_q[POST_EX-1].reg_write;
    assign bus.wb_result_src = stage_q[POST_EX-1].result_src;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: each stimulus cycle pushes the
// hand-computed expected EX/MEM/WB view into a queue; a monitor pops and
// compares it 2 time units after the following negedge.
module tb_decode_ctrl_pipe;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_ctrl_pipe_if #(.ALUCTRL_W(4)) bus ();

    decode_ctrl_pipe #(.ALUCTRL_W(4), .POST_EX(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // {imm_src, ex_valid, alu_src, alu_a_pc, alu_ctrl, pcsrc, jalr,
    //  mem_valid, mem_write, wb_valid, reg_write, result_src, trap}
    typedef logic [18:0] obs_t;

    localparam logic [8:0] EX0     = 9'b0_0_0_0000_0_0;
    localparam logic [8:0] EXADD   = 9'b1_0_0_0000_0_0;
    localparam logic [8:0] EXLS    = 9'b1_1_0_0000_0_0;
    localparam logic [8:0] EXSUB   = 9'b1_0_0_0001_0_0;
    localparam logic [8:0] EXBEQT  = 9'b1_0_0_0001_1_0;
    localparam logic [8:0] EXBLTUN = 9'b1_0_0_1001_0_0;
    localparam logic [8:0] EXBGEUT = 9'b1_0_0_1001_1_0;
    localparam logic [8:0] EXJAL   = 9'b1_1_1_0000_1_0;
    localparam logic [1:0] M0 = 2'b00, MV = 2'b10, MST = 2'b11;
    localparam logic [3:0] W0 = 4'b0000, WALU = 4'b1100, WLD = 4'b1101;
    localparam logic [3:0] WNW = 4'b1000, WPC = 4'b1110, WIMM = 4'b1111;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A023;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BLTU = 32'h0020E063;
    localparam logic [31:0] I_BGEU = 32'h0020F063;
    localparam logic [31:0] I_LUI  = 32'h000011B7;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Drive one cycle of stimulus and queue what must be visible this cycle
    task automatic step(input string nm, input logic r, input logic v,
                        input logic [31:0] ins, input logic st, input logic fl,
                        input logic z, input logic lt, input logic ltu,
                        input logic [2:0] imm, input logic [8:0] ex,
                        input logic [1:0] mem, input logic [3:0] wb,
                        input logic trp);
        @(negedge clk);
        rst           = r;
        bus.id_valid  = v;
        bus.id_instr  = ins;
        bus.stall     = st;
        bus.flush_ext = fl;
        bus.ex_zero   = z;
        bus.ex_lt     = lt;
        bus.ex_ltu    = ltu;
        exp_q.push_back({imm, ex, mem, wb, trp});
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT view against the oldest queued expectation
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string n;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {bus.id_imm_src, bus.ex_valid, bus.ex_alu_src, bus.ex_alu_a_pc,
                 bus.ex_alu_ctrl, bus.ex_pcsrc, bus.ex_jalr, bus.mem_valid,
                 bus.mem_mem_write, bus.wb_valid, bus.wb_reg_write,
                 bus.wb_result_src, bus.trap};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s actual=%b required=%b", n, a, e);
            end else begin
                $display("ok   %s obs=%b", n, a);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.id_valid  = 1'b0;
        bus.id_instr  = '0;
        bus.stall     = 1'b0;
        bus.flush_ext = 1'b0;
        bus.ex_zero   = 1'b0;
        bus.ex_lt     = 1'b0;
        bus.ex_ltu    = 1'b0;
        repeat (2) @(posedge clk);
        //    name                   r  v  instr   st fl z  lt ltu imm     ex       mem  wb    trap
        step("reset_state",          0, 0, '0,     0, 0, 0, 0, 0, 3'b000, EX0,     M0,  W0,   0);
        step("idle_bubble",          0, 1, I_ADD,  0, 0, 0, 0, 0, 3'b000, EX0,     M0,  W0,   0);
        step("add_in_ex",            0, 1, I_LW,   0, 0, 0, 0, 0, 3'b000, EXADD,   M0,  W0,   0);
        step("lw_in_ex_stall",       0, 1, I_ADD,  1, 0, 0, 0, 0, 3'b000, EXLS,    MV,  W0,   0);
        step("stall_bubble",         0, 1, I_ADD,  0, 0, 0, 0, 0, 3'b000, EX0,     MV,  WALU, 0);
        step("lw_reaches_wb",        0, 1, I_SW,   0, 0, 0, 0, 0, 3'b001, EXADD,   M0,  WLD,  0);
        step("sw_in_ex",             0, 1, I_SUB,  0, 0, 0, 0, 0, 3'b000, EXLS,    MV,  W0,   0);
        step("sub_ex_store_mem",     0, 1, I_BEQ,  0, 0, 0, 0, 0, 3'b010, EXSUB,   MST, WALU, 0);
        step("beq_taken",            0, 1, I_ADD,  0, 0, 1, 0, 0, 3'b000, EXBEQT,  MV,  WNW,  0);
        step("beq_squash",           0, 1, I_BLTU, 0, 0, 1, 0, 0, 3'b010, EX0,     MV,  WALU, 0);
        step("bltu_not_taken",       0, 1, I_BGEU, 0, 0, 0, 1, 0, 3'b010, EXBLTUN, M0,  WNW,  0);
        step("bgeu_taken",           0, 1, I_LUI,  0, 0, 0, 1, 0, 3'b100, EXBGEUT, MV,  W0,   0);
        step("bgeu_squash",          0, 1, I_JAL,  0, 0, 0, 0, 0, 3'b011, EX0,     MV,  WNW,  0);
        step("jal_taken",            0, 1, I_LUI,  0, 0, 0, 0, 0, 3'b100, EXJAL,   M0,  WNW,  0);
        step("jal_squash",           0, 1, I_LUI,  0, 0, 0, 0, 0, 3'b100, EX0,     MV,  W0,   0);
        step("lui_ex_flush_ext",     0, 1, I_ADD,  0, 1, 0, 0, 0, 3'b000, EXLS,    M0,  WPC,  0);
        step("flush_ext_bubble",     0, 0, '0,     1, 1, 0, 0, 0, 3'b000, EX0,     MV,  W0,   0);
        step("idle_stall_flush",     0, 1, I_SW,   0, 0, 0, 0, 0, 3'b001, EX0,     M0,  WIMM, 0);
        step("sw2_in_ex",            0, 0, '0,     0, 0, 0, 0, 0, 3'b000, EXLS,    M0,  W0,   0);
        step("sw2_in_mem",           0, 0, '0,     0, 0, 0, 0, 0, 3'b000, EX0,     MST, W0,   0);
        step("async_reset_mid_pipe", 1, 0, '0,     0, 0, 0, 0, 0, 3'b000, EX0,     M0,  W0,   0);
        step("reset_release",        0, 0, '0,     0, 0, 0, 0, 0, 3'b000, EX0,     M0,  W0,   0);
        step("illegal_issue",        0, 1, I_ILL,  0, 0, 0, 0, 0, 3'b000, EX0,     M0,  W0,   0);
        step("illegal_bubble",       0, 1, I_ADD,  0, 0, 0, 0, 0, 3'b000, EX0,     M0,  W0,   TRAP_EN);
        step("add_after_illegal",    0, 1, I_ADD,  0, 0, 0, 0, 0, 3'b000,
             TRAP_EN ? EX0 : EXADD, M0, W0, TRAP_EN);
        step("add2_after_illegal",   0, 0, '0,     0, 0, 0, 0, 0, 3'b000,
             TRAP_EN ? EX0 : EXADD, TRAP_EN ? M0 : MV, W0, TRAP_EN);
        step("drain_1",              0, 0, '0,     0, 0, 0, 0, 0, 3'b000,
             EX0, TRAP_EN ? M0 : MV, TRAP_EN ? W0 : WALU, TRAP_EN);
        step("drain_2",              0, 0, '0,     0, 0, 0, 0, 0, 3'b000,
             EX0, M0, TRAP_EN ? W0 : WALU, TRAP_EN);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
